// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard front end.
package ps2_pkg;

  // Frame receiver states; one state per field of an 11-bit PS/2 frame.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  // Scan-code prefixes that modify the following byte instead of being keys.
  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  // A queued key: extended flag on top of the 7-bit make code.
  localparam int ENTRY_W = 8;

  typedef struct packed {
    logic       ext;
    logic [6:0] code;
  } key_entry_t;

  // PS/2 uses odd parity across the data byte plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data_byte, input logic par_bit);
    return ^{par_bit, data_byte};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head (first-word fall-through).
// A push while full is dropped and flagged on push_drop, unless a pop
// happens in the same cycle, in which case both succeed.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     push_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

  // Accept/reject decisions and next pointer/occupancy values.
  always_comb begin
    do_pop    = pop && !empty;
    do_push   = push && (!full || do_pop);
    push_drop = push && !do_push;
    wr_ptr_d  = wr_ptr_q + AW'(do_push);
    rd_ptr_d  = rd_ptr_q + AW'(do_pop);
    count_d   = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ps2_key_fifo.sv
// PS/2 keyboard receiver: synchronises and de-glitches the PS/2 lines,
// assembles frames, folds E0/F0 prefixes into the following byte and
// queues make codes for the CPU key register.
module ps2_key_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          key_pop,
  input  logic                          ovf_clr,
  output logic [6:0]                    key_code,
  output logic                          key_ext,
  output logic                          key_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]            clk_sync_q, clk_sync_d;
  logic [1:0]            data_sync_q, data_sync_d;
  logic [FILTER_LEN-1:0] filt_win_q, filt_win_d;
  logic                  filt_clk_q, filt_clk_d;
  logic                  sample_evt, data_bit;

  ps2_state_e            state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  ext_q, ext_d;
  logic                  brk_q, brk_d;
  logic                  push_q, push_d;
  key_entry_t            push_data_q, push_data_d;
  logic [TW-1:0]         to_cnt_q, to_cnt_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overflow_q, overflow_d;
  logic                  err_evt;

  logic [ENTRY_W-1:0]    head_data;
  logic                  fifo_empty, fifo_full, fifo_drop;

  // Synchroniser shift and glitch filter: the filtered clock only moves
  // once the whole window agrees on the new level.
  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk};
    data_sync_d = {data_sync_q[0], ps2_data};
    filt_win_d  = {filt_win_q[FILTER_LEN-2:0], clk_sync_q[1]};
    filt_clk_d  = filt_clk_q;
    if (&filt_win_q) begin
      filt_clk_d = 1'b1;
    end else if (~|filt_win_q) begin
      filt_clk_d = 1'b0;
    end
  end

  // A sample event is the cycle in which the filtered clock decides to fall.
  assign sample_evt = filt_clk_q && ~|filt_win_q;
  assign data_bit   = data_sync_q[1];

  // Frame FSM, prefix tracking, decode and inactivity timeout.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    to_cnt_d    = to_cnt_q;
    err_evt     = 1'b0;

    case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        if (sample_evt && !data_bit) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end
      end
      DATA: begin
        if (sample_evt) begin
          shift_d   = {data_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (sample_evt) begin
          par_d   = data_bit;
          state_d = STOP;
        end
      end
      STOP: begin
        if (sample_evt) begin
          state_d = IDLE;
          if (data_bit && odd_parity_ok(shift_q, par_q)) begin
            if (shift_q == SC_EXT) begin
              ext_d = 1'b1;
            end else if (shift_q == SC_BRK) begin
              brk_d = 1'b1;
            end else begin
              // Break codes and codes outside the 7-bit range never queue.
              if (!brk_q && !shift_q[7]) begin
                push_d      = 1'b1;
                push_data_d = '{ext: ext_q, code: shift_q[6:0]};
              end
              ext_d = 1'b0;
              brk_d = 1'b0;
            end
          end else begin
            err_evt = 1'b1;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A stalled device mid-frame abandons the frame and its prefixes.
    if (state_q != IDLE) begin
      if (sample_evt) begin
        to_cnt_d = '0;
      end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d  = IDLE;
        to_cnt_d = '0;
        err_evt  = 1'b1;
        ext_d    = 1'b0;
        brk_d    = 1'b0;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end
  end

  // Sticky flags: a new event in the same cycle as a clear wins.
  always_comb begin
    frame_err_d = frame_err_q;
    overflow_d  = overflow_q;
    if (ovf_clr) begin
      frame_err_d = 1'b0;
      overflow_d  = 1'b0;
    end
    if (err_evt) begin
      frame_err_d = 1'b1;
    end
    if (fifo_drop) begin
      overflow_d = 1'b1;
    end
  end

  // All front-end state registers; lines idle high, so sync/filter reset to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_win_q  <= '1;
      filt_clk_q  <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      to_cnt_q    <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      filt_win_q  <= filt_win_d;
      filt_clk_q  <= filt_clk_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      to_cnt_q    <= to_cnt_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_q),
    .push_data (push_data_q),
    .pop       (key_pop),
    .head_data (head_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count),
    .push_drop (fifo_drop)
  );

  assign key_valid = !fifo_empty;
  assign key_code  = head_data[6:0];
  assign key_ext   = head_data[7];
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Directed bench for ps2_key_fifo: bit-bangs PS/2 frames and checks the queue.
module tb_ps2_key_fifo;

  localparam int H       = 10;     // clk cycles per PS/2 clock half period
  localparam int TIMEOUT = 50000;

  logic       clk = 1'b0;
  logic       rst_n, ps2_clk, ps2_data, key_pop, ovf_clr;
  logic [6:0] key_code;
  logic       key_ext, key_valid, overflow, frame_err;
  logic [3:0] fifo_count;

  int tests_run    = 0;
  int tests_failed = 0;

  ps2_key_fifo #(
    .FIFO_DEPTH     (8),
    .FILTER_LEN     (4),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .key_pop    (key_pop),
    .ovf_clr    (ovf_clr),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .key_valid  (key_valid),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_cycles(H);
    ps2_clk = 1'b0;
    wait_cycles(H);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    $display("[TB] frame 0x%02h%s", b, bad_par ? " (bad parity)" : "");
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    wait_cycles(2 * H);
  endtask

  task automatic pop_one();
    key_pop = 1'b1;
    wait_cycles(1);
    key_pop = 1'b0;
    wait_cycles(1);
  endtask

  task automatic pulse_clr();
    ovf_clr = 1'b1;
    wait_cycles(1);
    ovf_clr = 1'b0;
    wait_cycles(1);
  endtask

  task automatic test_reset();
    wait_cycles(2);
    tests_run++; if (key_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %0b want 0", key_valid); end
    rst_n = 1'b1;
    wait_cycles(3);
    tests_run++; if (key_code !== 7'h00) begin tests_failed++; $display("FAIL rst_code: got %h want 00", key_code); end
    tests_run++; if (key_ext !== 1'b0) begin tests_failed++; $display("FAIL rst_ext: got %0b want 0", key_ext); end
    tests_run++; if (fifo_count !== 4'd0) begin tests_failed++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL rst_ovf: got %0b want 0", overflow); end
    tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL rst_ferr: got %0b want 0", frame_err); end
  endtask

  task automatic test_make();
    send_frame(8'h29, 1'b0);
    tests_run++; if (key_valid !== 1'b1) begin tests_failed++; $display("FAIL make_valid: got %0b want 1", key_valid); end
    tests_run++; if (key_code !== 7'h29) begin tests_failed++; $display("FAIL make_code: got %h want 29", key_code); end
    tests_run++; if (key_ext !== 1'b0) begin tests_failed++; $display("FAIL make_ext: got %0b want 0", key_ext); end
    tests_run++; if (fifo_count !== 4'd1) begin tests_failed++; $display("FAIL make_count: got %0d want 1", fifo_count); end
    pop_one();
    tests_run++; if (key_valid !== 1'b0) begin tests_failed++; $display("FAIL make_pop_valid: got %0b want 0", key_valid); end
    tests_run++; if (key_code !== 7'h00) begin tests_failed++; $display("FAIL make_pop_code: got %h want 00", key_code); end
  endtask

  task automatic test_ext();
    send_frame(8'hE0, 1'b0);
    tests_run++; if (fifo_count !== 4'd0) begin tests_failed++; $display("FAIL ext_prefix_count: got %0d want 0", fifo_count); end
    send_frame(8'h6B, 1'b0);
    tests_run++; if (fifo_count !== 4'd1) begin tests_failed++; $display("FAIL ext_count: got %0d want 1", fifo_count); end
    tests_run++; if (key_code !== 7'h6B) begin tests_failed++; $display("FAIL ext_code: got %h want 6b", key_code); end
    tests_run++; if (key_ext !== 1'b1) begin tests_failed++; $display("FAIL ext_flag: got %0b want 1", key_ext); end
    pop_one();
  endtask

  task automatic test_break();
    send_frame(8'hF0, 1'b0);
    send_frame(8'h29, 1'b0);
    tests_run++; if (fifo_count !== 4'd0) begin tests_failed++; $display("FAIL brk_count: got %0d want 0", fifo_count); end
    send_frame(8'h29, 1'b0);
    tests_run++; if (fifo_count !== 4'd1) begin tests_failed++; $display("FAIL brk_next_count: got %0d want 1", fifo_count); end
    tests_run++; if (key_code !== 7'h29) begin tests_failed++; $display("FAIL brk_next_code: got %h want 29", key_code); end
    tests_run++; if (key_ext !== 1'b0) begin tests_failed++; $display("FAIL brk_next_ext: got %0b want 0", key_ext); end
    pop_one();
    send_frame(8'h83, 1'b0);
    tests_run++; if (fifo_count !== 4'd0) begin tests_failed++; $display("FAIL high_bit_count: got %0d want 0", fifo_count); end
  endtask

  task automatic test_bad_parity();
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b1);
    tests_run++; if (fifo_count !== 4'd0) begin tests_failed++; $display("FAIL par_count: got %0d want 0", fifo_count); end
    tests_run++; if (frame_err !== 1'b1) begin tests_failed++; $display("FAIL par_ferr: got %0b want 1", frame_err); end
    pulse_clr();
    tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL par_clr: got %0b want 0", frame_err); end
    // The error also discarded the pending E0 prefix.
    send_frame(8'h6B, 1'b0);
    tests_run++; if (key_ext !== 1'b0) begin tests_failed++; $display("FAIL par_prefix_ext: got %0b want 0", key_ext); end
    tests_run++; if (key_code !== 7'h6B) begin tests_failed++; $display("FAIL par_prefix_code: got %h want 6b", key_code); end
    pop_one();
  endtask

  task automatic test_overflow();
    logic [6:0] exp_q [8];
    bit         found;
    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b0);
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_at_full: got %0b want 0", overflow); end
    send_frame(8'h18, 1'b0);
    tests_run++; if (fifo_count !== 4'd8) begin tests_failed++; $display("FAIL ovf_count: got %0d want 8", fifo_count); end
    tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag: got %0b want 1", overflow); end
    tests_run++; if (key_code !== 7'h10) begin tests_failed++; $display("FAIL ovf_head: got %h want 10", key_code); end
    // Pop exactly in the cycle the new entry is pushed while full.
    found = 1'b0;
    fork
      send_frame(8'h19, 1'b0);
      begin
        for (int c = 0; c < 1000 && !found; c++) begin
          @(negedge clk);
          if (dut.push_q === 1'b1) found = 1'b1;
        end
        if (found) begin
          key_pop = 1'b1;
          @(negedge clk);
          key_pop = 1'b0;
        end
      end
    join
    tests_run++; if (!found) begin tests_failed++; $display("FAIL pushpop_timing: got no push want push within 1000 cycles"); end
    tests_run++; if (fifo_count !== 4'd8) begin tests_failed++; $display("FAIL pushpop_count: got %0d want 8", fifo_count); end
    exp_q = '{7'h11, 7'h12, 7'h13, 7'h14, 7'h15, 7'h16, 7'h17, 7'h19};
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (key_code !== exp_q[i]) begin tests_failed++; $display("FAIL drain_%0d: got %h want %h", i, key_code, exp_q[i]); end
      pop_one();
    end
    tests_run++; if (key_valid !== 1'b0) begin tests_failed++; $display("FAIL drain_valid: got %0b want 0", key_valid); end
    pop_one();
    tests_run++; if (fifo_count !== 4'd0) begin tests_failed++; $display("FAIL empty_pop_count: got %0d want 0", fifo_count); end
    pulse_clr();
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_clr: got %0b want 0", overflow); end
  endtask

  task automatic test_timeout();
    $display("[TB] partial frame, 3 data bits then stall");
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    wait_cycles(TIMEOUT - 100);
    tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL to_early: got %0b want 0", frame_err); end
    wait_cycles(200);
    tests_run++; if (frame_err !== 1'b1) begin tests_failed++; $display("FAIL to_ferr: got %0b want 1", frame_err); end
    tests_run++; if (fifo_count !== 4'd0) begin tests_failed++; $display("FAIL to_count: got %0d want 0", fifo_count); end
    ps2_data = 1'b1;
    pulse_clr();
    send_frame(8'h72, 1'b0);
    tests_run++; if (key_code !== 7'h72) begin tests_failed++; $display("FAIL to_next_code: got %h want 72", key_code); end
    tests_run++; if (fifo_count !== 4'd1) begin tests_failed++; $display("FAIL to_next_count: got %0d want 1", fifo_count); end
  endtask

  task automatic test_reset_midframe();
    send_frame(8'h75, 1'b1);
    send_frame(8'hE0, 1'b0);
    $display("[TB] partial frame then reset pulse");
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    rst_n = 1'b0;
    wait_cycles(1);
    tests_run++; if (key_valid !== 1'b0) begin tests_failed++; $display("FAIL mrst_valid: got %0b want 0", key_valid); end
    tests_run++; if (key_code !== 7'h00) begin tests_failed++; $display("FAIL mrst_code: got %h want 00", key_code); end
    tests_run++; if (fifo_count !== 4'd0) begin tests_failed++; $display("FAIL mrst_count: got %0d want 0", fifo_count); end
    tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL mrst_ferr: got %0b want 0", frame_err); end
    ps2_data = 1'b1;
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(5);
    send_frame(8'h6B, 1'b0);
    tests_run++; if (key_code !== 7'h6B) begin tests_failed++; $display("FAIL mrst_next_code: got %h want 6b", key_code); end
    tests_run++; if (key_ext !== 1'b0) begin tests_failed++; $display("FAIL mrst_next_ext: got %0b want 0", key_ext); end
  endtask

  initial begin
    rst_n    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    key_pop  = 1'b0;
    ovf_clr  = 1'b0;
    test_reset();
    test_make();
    test_ext();
    test_break();
    test_bad_parity();
    test_overflow();
    test_timeout();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
